sss_search_ctrl: RTL

- Sequences an exhaustive SSS hypothesis search over the shared 62-bit correlator.
- On start: latches one received SSS, fetches each candidate local sequence from the sequence generator, drives it into the correlator and collects the registered score.
- Tracks the best-scoring candidate and reports index, score and a found flag against a detection threshold.
- Sits between cell-search control (start/done) and the correlator plus sequence generator pair.

---
 rtl/sss_pkg.sv | 19 +
 rtl/sss_search_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sss_pkg.sv
// Shared types and constants for the SSS hypothesis search controller.
// Sequence/score widths and the FSM state encoding live here.
package sss_pkg;

    localparam int SSS_LEN  = 62;
    localparam int NUM_NID1 = 168;
    localparam int SCORE_W  = 32;

    typedef logic [SSS_LEN-1:0] sss_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_CMP   = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/sss_search_ctrl.sv
// Exhaustive SSS search: fetch each candidate, correlate, keep the best.
// Optional SSS_PEAK_MARGIN_EN adds second-best tracking and a margin test.
module sss_search_ctrl
    import sss_pkg::*;
#(
    parameter int NUM_CAND = NUM_NID1,
    parameter int IDX_W    = 8,
    parameter int CORR_LAT = 1,
`ifdef SSS_PEAK_MARGIN_EN
    parameter int MARGIN   = 6,
`endif
    parameter int THRESH   = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [61:0]      received_sss_in,
    output logic             seq_req,
    output logic [IDX_W-1:0] seq_idx,
    input  logic             seq_valid,
    input  logic [61:0]      seq_data,
    output logic [61:0]      corr_received,
    output logic [61:0]      corr_local,
    input  logic [31:0]      corr_result,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] best_idx,
    output logic [31:0]      best_score,
    output logic             found
`ifdef SSS_PEAK_MARGIN_EN
    ,
    output logic [31:0]      second_score
`endif
);

    localparam int WCNT_W = (CORR_LAT > 1) ? $clog2(CORR_LAT) : 1;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WCNT_W-1:0] r_wcnt;
    sss_t             r_rx;
    sss_t             r_loc;
    score_t           r_best;
    logic [IDX_W-1:0] r_bidx;
    logic             r_found;
`ifdef SSS_PEAK_MARGIN_EN
    score_t           r_second;
    score_t           w_nsec;
`endif

    logic   w_last;
    logic   w_first;
    logic   w_upd;
    score_t w_nbest;
    logic   w_found;

    assign w_last  = (r_idx == IDX_W'(NUM_CAND - 1));
    assign w_first = (r_idx == '0);

    // Strict compare so ties keep the earlier (lower) index.
    always_comb begin
        w_upd   = w_first || (corr_result > r_best);
        w_nbest = w_upd ? corr_result : r_best;
`ifdef SSS_PEAK_MARGIN_EN
        w_nsec = r_second;
        if (w_first)
            w_nsec = '0;
        else if (corr_result > r_best)
            w_nsec = r_best;
        else if (corr_result > r_second)
            w_nsec = corr_result;
        w_found = (w_nbest >= score_t'(THRESH)) &&
                  ((w_nbest - w_nsec) >= score_t'(MARGIN));
`else
        w_found = (w_nbest >= score_t'(THRESH));
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_rx     <= '0;
            r_loc    <= '0;
            r_best   <= '0;
            r_bidx   <= '0;
            r_found  <= 1'b0;
`ifdef SSS_PEAK_MARGIN_EN
            r_second <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rx     <= received_sss_in;
                        r_best   <= '0;
                        r_bidx   <= '0;
                        r_found  <= 1'b0;
                        r_idx    <= '0;
`ifdef SSS_PEAK_MARGIN_EN
                        r_second <= '0;
`endif
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (seq_valid) begin
                        r_loc   <= seq_data;
                        r_wcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == WCNT_W'(CORR_LAT - 1))
                        r_state <= S_CMP;
                    else
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                end
                S_CMP: begin
                    r_best <= w_nbest;
                    if (w_upd)
                        r_bidx <= r_idx;
`ifdef SSS_PEAK_MARGIN_EN
                    r_second <= w_nsec;
`endif
                    if (w_last) begin
                        r_found <= w_found;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign seq_req       = (r_state == S_FETCH);
    assign seq_idx       = r_idx;
    assign corr_received = r_rx;
    assign corr_local    = r_loc;
    assign busy          = (r_state == S_FETCH) ||
                           (r_state == S_WAIT)  ||
                           (r_state == S_CMP);
    assign done          = (r_state == S_DONE);
    assign best_idx      = r_bidx;
    assign best_score    = r_best;
    assign found         = r_found;
`ifdef SSS_PEAK_MARGIN_EN
    assign second_score  = r_second;
`endif

endmodule
